uart_frame_parser: RTL and testbench

Receive-side framing stage between the UART core's RX AXI-stream output and the arithmetic controller. It assembles the raw byte stream into fixed 5-byte command frames (sync, opcode, operand A, operand B, checksum) and validates each frame's XOR checksum. It presents accepted frames as one parallel word under a valid/ready handshake. It also drops malformed or stalled frames and counts them for debug.

---
 rtl/uart_frame_parser.sv | 145 ++++++++++++++
 tb/tb_uart_frame_parser.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - assembles 5-byte sync/op/a/b/xor frames from a byte stream
module uart_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [7:0]       m_op,
    output logic [7:0]       m_a,
    output logic [7:0]       m_b,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_chk_cnt,
    output logic [CNT_W-1:0] err_to_cnt
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        GET_OP,
        GET_A,
        GET_B,
        GET_CHK,
        HOLD
    } state_t;

    state_t            state_q;
    logic [7:0]        op_q, a_q, b_q;
    logic [7:0]        m_op_q, m_a_q, m_b_q;
    logic              m_valid_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [CNT_W-1:0]  frame_cnt_q, err_chk_cnt_q, err_to_cnt_q;

    logic              accept_d;
    logic              in_frame_d;
    logic              to_expire_d;
    logic              chk_ok_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // HOLD is the only state that refuses bytes; everything else consumes one per cycle
    assign s_axis_tready = (state_q != HOLD);
    assign accept_d      = s_axis_tvalid && s_axis_tready;
    assign in_frame_d    = (state_q == GET_OP) || (state_q == GET_A) ||
                           (state_q == GET_B)  || (state_q == GET_CHK);
    // an accepted byte always beats an expiring inter-byte timer
    assign to_expire_d   = in_frame_d && !accept_d && (to_cnt_q == TO_LAST);
    assign chk_ok_d      = (s_axis_tdata == (op_q ^ a_q ^ b_q));

    assign busy        = in_frame_d;
    assign m_op        = m_op_q;
    assign m_a         = m_a_q;
    assign m_b         = m_b_q;
    assign m_valid     = m_valid_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_chk_cnt = err_chk_cnt_q;
    assign err_to_cnt  = err_to_cnt_q;

    // frame FSM, inter-byte timer, output register and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            m_op_q        <= '0;
            m_a_q         <= '0;
            m_b_q         <= '0;
            m_valid_q     <= 1'b0;
            to_cnt_q      <= '0;
            frame_cnt_q   <= '0;
            err_chk_cnt_q <= '0;
            err_to_cnt_q  <= '0;
        end else begin
            if (in_frame_d) begin
                to_cnt_q <= accept_d ? '0 : to_cnt_q + TO_W'(1);
            end
            if (to_expire_d) begin
                err_to_cnt_q <= sat_inc(err_to_cnt_q);
                state_q      <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept_d && s_axis_tdata == SYNC_BYTE) begin
                            to_cnt_q <= '0;
                            state_q  <= GET_OP;
                        end
                    end
                    GET_OP: begin
                        if (accept_d) begin
                            op_q    <= s_axis_tdata;
                            state_q <= GET_A;
                        end
                    end
                    GET_A: begin
                        if (accept_d) begin
                            a_q     <= s_axis_tdata;
                            state_q <= GET_B;
                        end
                    end
                    GET_B: begin
                        if (accept_d) begin
                            b_q     <= s_axis_tdata;
                            state_q <= GET_CHK;
                        end
                    end
                    GET_CHK: begin
                        if (accept_d) begin
                            if (chk_ok_d) begin
                                m_op_q      <= op_q;
                                m_a_q       <= a_q;
                                m_b_q       <= b_q;
                                m_valid_q   <= 1'b1;
                                frame_cnt_q <= sat_inc(frame_cnt_q);
                                state_q     <= HOLD;
                            end else begin
                                err_chk_cnt_q <= sat_inc(err_chk_cnt_q);
                                state_q       <= IDLE;
                            end
                        end
                    end
                    HOLD: begin
                        if (m_ready) begin
                            m_valid_q <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - randomized scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;

    localparam int T    = 16;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [7:0]    m_op, m_a, m_b;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          busy;
    logic [CW-1:0] frame_cnt, err_chk_cnt, err_to_cnt;

    uart_frame_parser #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(T),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_op         (m_op),
        .m_a          (m_a),
        .m_b          (m_b),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .err_chk_cnt  (err_chk_cnt),
        .err_to_cnt   (err_to_cnt)
    );

    always #5 clk = ~clk;

    // stimulus tokens: 0..255 byte, 256+n idle n cycles, 1000 reset,
    // 2000+n hold m_ready low n cycles, 4000 switch to randomized pacing
    int stim[$];

    typedef struct {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } frame_t;
    frame_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: bytes gathered since sync, idle gap, hold flag, counters
    bit         m_in_frame;
    logic [7:0] m_buf[$];
    int         m_gap;
    bit         m_hold;
    int         m_fcnt, m_ccnt, m_tcnt;
    logic [7:0] m_lop, m_la, m_lb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0;
        m_buf.delete();
        m_gap  = 0;
        m_hold = 0;
        m_fcnt = 0;
        m_ccnt = 0;
        m_tcnt = 0;
        m_lop  = '0;
        m_la   = '0;
        m_lb   = '0;
        exp_q.delete();
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic push_frame(input logic [7:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] chk);
        stim.push_back(32'hA5);
        stim.push_back(int'(op));
        stim.push_back(int'(a));
        stim.push_back(int'(b));
        stim.push_back(int'(chk));
    endtask

    task automatic push_good(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        push_frame(op, a, b, op ^ a ^ b);
    endtask

    // advance the model across the coming clock edge using the driven inputs
    task automatic model_step(output bit acc);
        frame_t f;
        logic [7:0] x;
        acc = 0;
        if (rst) begin
            model_reset();
        end else if (m_hold) begin
            if (m_ready) m_hold = 0;
        end else if (s_axis_tvalid) begin
            acc = 1;
            if (!m_in_frame) begin
                if (s_axis_tdata == 8'hA5) begin
                    m_in_frame = 1;
                    m_buf.delete();
                    m_gap = 0;
                end
            end else begin
                m_gap = 0;
                if (m_buf.size() < 3) begin
                    m_buf.push_back(s_axis_tdata);
                end else begin
                    x = m_buf[0] ^ m_buf[1] ^ m_buf[2];
                    if (x == s_axis_tdata) begin
                        f.op = m_buf[0];
                        f.a  = m_buf[1];
                        f.b  = m_buf[2];
                        exp_q.push_back(f);
                        m_lop  = f.op;
                        m_la   = f.a;
                        m_lb   = f.b;
                        m_hold = 1;
                        m_fcnt = sat(m_fcnt);
                    end else begin
                        m_ccnt = sat(m_ccnt);
                    end
                    m_in_frame = 0;
                end
            end
        end else if (m_in_frame) begin
            m_gap++;
            if (m_gap >= T) begin
                m_tcnt = sat(m_tcnt);
                m_in_frame = 0;
            end
        end
    endtask

    // monitor: every cycle m_valid is high, the presented fields must match the oldest expected frame
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_valid", 32'(m_valid), 32'd0);
                end else begin
                    check("sb_op", 32'(m_op), 32'(exp_q[0].op));
                    check("sb_a",  32'(m_a),  32'(exp_q[0].a));
                    check("sb_b",  32'(m_b),  32'(exp_q[0].b));
                    if (m_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit dense = 1;
        bit pending = 0;
        bit acc;
        int mr_low = 0;
        int drain = 0;
        int cyc = 0;
        logic [7:0] op, a, b;

        // directed section
        push_good(8'h01, 8'h12, 8'h34);
        push_frame(8'h01, 8'h12, 8'h34, 8'h00);
        push_good(8'h5A, 8'h11, 8'h22);
        stim.push_back(32'h00); stim.push_back(32'hFF); stim.push_back(32'hA5);
        push_frame(8'h02, 8'hA5, 8'hA5, 8'h02);
        push_good(8'h02, 8'hA5, 8'hA5);
        stim.push_back(32'hA5); stim.push_back(32'h01); stim.push_back(256 + 20);
        push_good(8'h33, 8'h44, 8'h55);
        stim.push_back(32'hA5); stim.push_back(32'h01); stim.push_back(256 + T - 1);
        stim.push_back(32'h12); stim.push_back(32'h34); stim.push_back(32'h27);
        stim.push_back(32'hA5); stim.push_back(32'h01); stim.push_back(32'h12);
        stim.push_back(256 + T);
        push_good(8'h0F, 8'hF0, 8'hAA);
        stim.push_back(2000 + 12);
        push_good(8'h10, 8'h20, 8'h30);
        push_good(8'h40, 8'h50, 8'h60);
        stim.push_back(32'hA5); stim.push_back(32'h01); stim.push_back(32'h12);
        stim.push_back(1000);
        push_good(8'h77, 8'h88, 8'h99);
        repeat (5) push_frame(8'h01, 8'h02, 8'h03, 8'hFF);
        stim.push_back(4000);

        // randomized section
        repeat (80) begin
            int r = $urandom_range(99);
            op = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
            if ($urandom_range(9) == 0) a = 8'hA5;
            if (r < 45) push_good(op, a, b);
            else if (r < 60) push_frame(op, a, b, op ^ a ^ b ^ 8'($urandom_range(1, 255)));
            else if (r < 70) stim.push_back(int'(8'($urandom)));
            else if (r < 80) begin
                stim.push_back(32'hA5);
                repeat ($urandom_range(0, 3)) stim.push_back(int'(8'($urandom)));
                stim.push_back(256 + T + $urandom_range(0, 4));
            end
            else if (r < 90) stim.push_back(2000 + $urandom_range(1, 15));
            else if (r < 93) stim.push_back(1000);
            else stim.push_back(256 + $urandom_range(1, T - 1));
        end

        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        while (drain < 10 && cyc < 30000) begin
            cyc++;
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            check("tready",  32'(s_axis_tready), 32'(!m_hold));
            check("m_valid", 32'(m_valid),       32'(m_hold));
            check("busy",    32'(busy),          32'(m_in_frame));
            check("frame_cnt",   32'(frame_cnt),   32'(m_fcnt));
            check("err_chk_cnt", 32'(err_chk_cnt), 32'(m_ccnt));
            check("err_to_cnt",  32'(err_to_cnt),  32'(m_tcnt));
            check("m_op_held", 32'(m_op), 32'(m_lop));
            check("m_a_held",  32'(m_a),  32'(m_la));
            check("m_b_held",  32'(m_b),  32'(m_lb));

            rst = 1'b0;
            if (!pending) begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = 8'($urandom);
                while (stim.size() > 0 && stim[0] >= 2000) begin
                    if (stim[0] == 4000) dense = 0;
                    else mr_low = stim[0] - 2000;
                    void'(stim.pop_front());
                end
                if (stim.size() == 0) begin
                    drain++;
                end else if (stim[0] == 1000) begin
                    rst = 1'b1;
                    void'(stim.pop_front());
                end else if (stim[0] > 256) begin
                    stim[0] = stim[0] - 1;
                    if (stim[0] == 256) void'(stim.pop_front());
                end else if (dense || $urandom_range(99) < 70) begin
                    s_axis_tvalid = 1'b1;
                    s_axis_tdata  = 8'(stim[0]);
                end
            end
            if (mr_low > 0) begin
                m_ready = 1'b0;
                mr_low--;
            end else begin
                m_ready = dense ? 1'b1 : ($urandom_range(99) < 75);
            end
            if (drain > 0) m_ready = 1'b1;

            model_step(acc);
            if (acc) void'(stim.pop_front());
            pending = s_axis_tvalid && !acc;
        end

        if (cyc >= 30000) check("cycle_budget", 32'(cyc), 32'd0);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
